// File: rtl/ofs_plat_avalon_mem_burst_arbiter.sv
// Round-robin, burst-aware arbiter sharing one Avalon memory sink among NUM_SRC sources.
// Command path is combinational (0 cycles); read data returns 1 cycle after the sink, steered by an in-order routing FIFO.
module ofs_plat_avalon_mem_burst_arbiter #(
   parameter int NUM_SRC          = 2,
   parameter int ADDR_WIDTH       = 27,
   parameter int DATA_WIDTH       = 512,
   parameter int BURST_CNT_WIDTH  = 7,
   parameter int MAX_RD_IN_FLIGHT = 64
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [NUM_SRC-1:0]                src_read,
   input  logic [NUM_SRC-1:0]                src_write,
   input  logic [NUM_SRC*ADDR_WIDTH-1:0]     src_address,
   input  logic [NUM_SRC*BURST_CNT_WIDTH-1:0] src_burstcount,
   input  logic [NUM_SRC*DATA_WIDTH-1:0]     src_writedata,
   input  logic [NUM_SRC*(DATA_WIDTH/8)-1:0] src_byteenable,
   output logic [NUM_SRC-1:0]                src_waitrequest,
   output logic [DATA_WIDTH-1:0]             src_readdata,
   output logic [NUM_SRC-1:0]                src_readdatavalid,
   output logic                              snk_read,
   output logic                              snk_write,
   output logic [ADDR_WIDTH-1:0]             snk_address,
   output logic [BURST_CNT_WIDTH-1:0]        snk_burstcount,
   output logic [DATA_WIDTH-1:0]             snk_writedata,
   output logic [DATA_WIDTH/8-1:0]           snk_byteenable,
   input  logic                              snk_waitrequest,
   input  logic [DATA_WIDTH-1:0]             snk_readdata,
   input  logic                              snk_readdatavalid,
   output logic                              rsp_error
);

   localparam int BE  = DATA_WIDTH / 8;
   localparam int BCW = BURST_CNT_WIDTH;
   localparam int SW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int FW  = (MAX_RD_IN_FLIGHT > 1) ? $clog2(MAX_RD_IN_FLIGHT) : 1;

   typedef enum logic [0:0] {IDLE = 1'b0, WR_LOCK = 1'b1} state_t;

   typedef struct packed {
      logic [SW-1:0]  src;
      logic [BCW-1:0] bcnt;
   } rd_route_t;

   logic [ADDR_WIDTH-1:0] addr_a [NUM_SRC];
   logic [BCW-1:0]        bcnt_a [NUM_SRC];
   logic [DATA_WIDTH-1:0] wdat_a [NUM_SRC];
   logic [BE-1:0]         be_a   [NUM_SRC];

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
      assign addr_a[i] = src_address[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign bcnt_a[i] = src_burstcount[i*BCW +: BCW];
      assign wdat_a[i] = src_writedata[i*DATA_WIDTH +: DATA_WIDTH];
      assign be_a[i]   = src_byteenable[i*BE +: BE];
   end

   state_t          state_q, state_d;
   logic [SW-1:0]   owner_q, owner_d;
   logic [SW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [BCW-1:0]  wr_beats_left_q, wr_beats_left_d;
   logic [BCW-1:0]  rd_beats_left_q, rd_beats_left_d;
   logic [FW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [FW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [FW:0]     cnt_q, cnt_d;
   logic            rsp_error_q, rsp_error_d;
   logic [NUM_SRC-1:0]    rdv_q, rdv_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   rd_route_t       fifo_mem [MAX_RD_IN_FLIGHT];
   rd_route_t       head;
   logic            fifo_full, fifo_empty;
   logic [NUM_SRC-1:0] eligible;
   logic            gnt_vld;
   logic [SW-1:0]   gnt_idx, cand;
   int              rr_idx;
   logic            sel_rd, sel_wr, accept, push, pop;
   logic [BCW-1:0]  cur_beats;

   assign fifo_full  = (cnt_q == (FW+1)'(MAX_RD_IN_FLIGHT));
   assign fifo_empty = (cnt_q == '0);
   assign head       = fifo_mem[rd_ptr_q];
   // Reads are only eligible while a routing slot is free; writes never need one.
   assign eligible   = src_write | (src_read & {NUM_SRC{!fifo_full}});

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         owner_q         <= '0;
         rr_ptr_q        <= '0;
         wr_beats_left_q <= '0;
         rd_beats_left_q <= '0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         cnt_q           <= '0;
         rsp_error_q     <= 1'b0;
         rdv_q           <= '0;
      end else begin
         state_q         <= state_d;
         owner_q         <= owner_d;
         rr_ptr_q        <= rr_ptr_d;
         wr_beats_left_q <= wr_beats_left_d;
         rd_beats_left_q <= rd_beats_left_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         cnt_q           <= cnt_d;
         rsp_error_q     <= rsp_error_d;
         rdv_q           <= rdv_d;
      end
   end

   always_ff @(posedge clk) begin
      rdata_q <= rdata_d;
      if (push) fifo_mem[wr_ptr_q] <= '{src: gnt_idx, bcnt: snk_burstcount};
   end

   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      rr_idx  = 0;
      if (state_q == WR_LOCK) begin
         gnt_vld = 1'b1;
         gnt_idx = owner_q;
      end else begin
         for (int k = 0; k < NUM_SRC; k++) begin
            rr_idx = int'(rr_ptr_q) + k;
            if (rr_idx >= NUM_SRC) rr_idx = rr_idx - NUM_SRC;
            cand = SW'(rr_idx);
            if (!gnt_vld && eligible[cand]) begin
               gnt_vld = 1'b1;
               gnt_idx = cand;
            end
         end
      end
      sel_wr = gnt_vld && src_write[gnt_idx];
      sel_rd = gnt_vld && (state_q == IDLE) && !src_write[gnt_idx] &&
               src_read[gnt_idx] && !fifo_full;
      snk_write      = sel_wr && reset_n;
      snk_read       = sel_rd && reset_n;
      snk_address    = addr_a[gnt_idx];
      snk_burstcount = bcnt_a[gnt_idx];
      snk_writedata  = wdat_a[gnt_idx];
      snk_byteenable = be_a[gnt_idx];
      src_waitrequest = '1;
      if (sel_wr || sel_rd) src_waitrequest[gnt_idx] = snk_waitrequest;
   end

   always_comb begin
      state_d         = state_q;
      owner_d         = owner_q;
      rr_ptr_d        = rr_ptr_q;
      wr_beats_left_d = wr_beats_left_q;
      accept          = (sel_wr || sel_rd) && !snk_waitrequest;
      push            = sel_rd && !snk_waitrequest;
      case (state_q)
         IDLE: begin
            if (accept) begin
               rr_ptr_d = (int'(gnt_idx) == NUM_SRC - 1) ? '0 : gnt_idx + SW'(1);
               if (sel_wr && snk_burstcount > BCW'(1)) begin
                  state_d         = WR_LOCK;
                  owner_d         = gnt_idx;
                  wr_beats_left_d = snk_burstcount - BCW'(1);
               end
            end
         end
         WR_LOCK: begin
            if (accept) begin
               wr_beats_left_d = wr_beats_left_q - BCW'(1);
               if (wr_beats_left_q == BCW'(1)) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      rdv_d           = '0;
      rdata_d         = snk_readdata;
      rsp_error_d     = rsp_error_q;
      rd_beats_left_d = rd_beats_left_q;
      cur_beats       = rd_beats_left_q;
      pop             = 1'b0;
      if (snk_readdatavalid) begin
         if (fifo_empty) begin
            rsp_error_d = 1'b1;
         end else begin
            // A zero count means the head burst has not started yet.
            cur_beats       = (rd_beats_left_q == '0) ? head.bcnt : rd_beats_left_q;
            rdv_d[head.src] = 1'b1;
            rd_beats_left_d = cur_beats - BCW'(1);
            pop             = (cur_beats == BCW'(1));
         end
      end
      wr_ptr_d = wr_ptr_q + FW'(push);
      rd_ptr_d = rd_ptr_q + FW'(pop);
      cnt_d    = cnt_q + (FW+1)'(push) - (FW+1)'(pop);
   end

   assign src_readdata      = rdata_q;
   assign src_readdatavalid = rdv_q;
   assign rsp_error         = rsp_error_q;

   a_bcnt_nonzero: assert property (@(posedge clk) disable iff (!reset_n)
      (snk_read || snk_write) |-> (snk_burstcount != '0));

endmodule

// File: tb/tb_ofs_plat_avalon_mem_burst_arbiter.sv
// Bench for the burst-aware Avalon arbiter: vector table for arbitration, scripted sequences for bursts/FIFO/errors.
module tb_ofs_plat_avalon_mem_burst_arbiter;

   localparam int NS = 2;
   localparam int AW = 27;
   localparam int DW = 64;
   localparam int BW = 7;

   logic               clk;
   logic               reset_n;
   logic [NS-1:0]      src_read, src_write;
   logic [NS*AW-1:0]   src_address;
   logic [NS*BW-1:0]   src_burstcount;
   logic [NS*DW-1:0]   src_writedata;
   logic [NS*DW/8-1:0] src_byteenable;
   logic [NS-1:0]      src_waitrequest;
   logic [DW-1:0]      src_readdata;
   logic [NS-1:0]      src_readdatavalid;
   logic               snk_read, snk_write;
   logic [AW-1:0]      snk_address;
   logic [BW-1:0]      snk_burstcount;
   logic [DW-1:0]      snk_writedata;
   logic [DW/8-1:0]    snk_byteenable;
   logic               snk_waitrequest;
   logic [DW-1:0]      snk_readdata;
   logic               snk_readdatavalid;
   logic               rsp_error;

   ofs_plat_avalon_mem_burst_arbiter #(
      .NUM_SRC(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .BURST_CNT_WIDTH(BW), .MAX_RD_IN_FLIGHT(4)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .src_read(src_read), .src_write(src_write), .src_address(src_address),
      .src_burstcount(src_burstcount), .src_writedata(src_writedata),
      .src_byteenable(src_byteenable), .src_waitrequest(src_waitrequest),
      .src_readdata(src_readdata), .src_readdatavalid(src_readdatavalid),
      .snk_read(snk_read), .snk_write(snk_write), .snk_address(snk_address),
      .snk_burstcount(snk_burstcount), .snk_writedata(snk_writedata),
      .snk_byteenable(snk_byteenable), .snk_waitrequest(snk_waitrequest),
      .snk_readdata(snk_readdata), .snk_readdatavalid(snk_readdatavalid),
      .rsp_error(rsp_error)
   );

   typedef struct {
      logic [1:0] rd;
      logic [1:0] wr;
      logic       sw;
      logic       e_rd;
      logic       e_wr;
      int         e_gnt;
      logic [1:0] e_wait;
   } vec_t;

   typedef struct { int src; int left; } rd_t;
   typedef struct { int src; logic [DW-1:0] d; int due; } rsp_t;
   typedef struct { logic wr; logic [AW-1:0] a; logic [DW-1:0] d; } cmd_t;

   rd_t  rdq[$];
   rsp_t exq[$];
   cmd_t acc_log[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [AW-1:0] src_addr(input int s);
      return (s == 0) ? AW'('h100) : AW'('h200);
   endfunction

   // Drive one sink response beat this cycle; the expected routed beat is due next cycle.
   task automatic beat_on(input logic [DW-1:0] d);
      snk_readdatavalid = 1'b1;
      snk_readdata      = d;
      if (rdq.size() > 0) begin
         exq.push_back('{rdq[0].src, d, cyc + 1});
         rdq[0].left = rdq[0].left - 1;
         if (rdq[0].left == 0) void'(rdq.pop_front());
      end
   endtask

   task automatic beats(input int n, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) begin
         beat_on(base + DW'(i));
         tick();
      end
      snk_readdatavalid = 1'b0;
      repeat (3) tick();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   always @(negedge clk) begin
      if (reset_n && (snk_read || snk_write) && !snk_waitrequest)
         acc_log.push_back('{snk_write, snk_address, snk_writedata});
      if (exq.size() > 0 && exq[0].due == cyc) begin
         chk("rsp_route", 64'(src_readdatavalid), 64'(1) << exq[0].src);
         chk("rsp_data", src_readdata, exq[0].d);
         void'(exq.pop_front());
      end else if (src_readdatavalid != '0) begin
         chk("rsp_unexpected", 64'(src_readdatavalid), 64'(0));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1);
   end

   initial begin
      vec_t vt[7];
      int   widx;

      vt[0] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 0, 2'b11};
      vt[1] = '{2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 0, 2'b11};
      vt[2] = '{2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 1, 2'b11};
      vt[3] = '{2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 0, 2'b10};
      vt[4] = '{2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1, 2'b01};
      vt[5] = '{2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1, 2'b01};
      vt[6] = '{2'b01, 2'b10, 1'b1, 1'b1, 1'b0, 0, 2'b11};

      reset_n           = 1'b0;
      src_read          = 2'b11;
      src_write         = 2'b11;
      src_address       = {src_addr(1), src_addr(0)};
      src_burstcount    = {BW'(1), BW'(1)};
      src_writedata     = '0;
      src_byteenable    = '1;
      snk_waitrequest   = 1'b0;
      snk_readdata      = '0;
      snk_readdatavalid = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_snk_cmd", {snk_read, snk_write}, 2'b00);
      chk("rst_rdv", 64'(src_readdatavalid), 64'(0));
      chk("rst_err", rsp_error, 1'b0);
      src_read  = '0;
      src_write = '0;
      reset_n   = 1'b1;

      // Arbitration vectors, applied back to back from reset (rr_ptr starts at 0).
      for (int i = 0; i < 7; i++) begin
         tick();
         src_read        = vt[i].rd;
         src_write       = vt[i].wr;
         snk_waitrequest = vt[i].sw;
         @(negedge clk);
         chk($sformatf("v%0d_cmd", i), {snk_read, snk_write}, {vt[i].e_rd, vt[i].e_wr});
         chk($sformatf("v%0d_wait", i), src_waitrequest, vt[i].e_wait);
         if (vt[i].e_rd || vt[i].e_wr)
            chk($sformatf("v%0d_addr", i), snk_address, src_addr(vt[i].e_gnt));
         if (vt[i].e_rd && !vt[i].sw) rdq.push_back('{vt[i].e_gnt, 1});
      end
      tick();
      src_read        = '0;
      src_write       = '0;
      snk_waitrequest = 1'b0;
      beats(2, 64'hA0);

      // Source 0 read burst of 4; responses with a gap.
      src_burstcount[0 +: BW] = BW'(4);
      src_read = 2'b01;
      @(negedge clk);
      chk("A_read", snk_read, 1'b1);
      chk("A_addr", snk_address, AW'('h100));
      chk("A_bcnt", snk_burstcount, BW'(4));
      rdq.push_back('{0, 4});
      tick();
      src_read = '0;
      @(negedge clk);
      chk("A_one_cmd", snk_read, 1'b0);
      tick();
      beat_on(64'hB0); tick();
      beat_on(64'hB1); tick();
      snk_readdatavalid = 1'b0; tick();
      beat_on(64'hB2); tick();
      beat_on(64'hB3); tick();
      snk_readdatavalid = 1'b0;
      repeat (3) tick();

      // Alternating grants from reset, filling the 4-deep routing FIFO.
      do_reset();
      src_burstcount = {BW'(1), BW'(1)};
      src_read = 2'b11;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("B_gnt%0d", k), {snk_read, snk_address}, {1'b1, src_addr(k % 2)});
         rdq.push_back('{k % 2, 1});
         tick();
      end
      src_read = 2'b01;
      src_write = 2'b10;
      src_writedata[DW +: DW] = 64'hC0FFEE;
      @(negedge clk);
      chk("C_full_cmd", {snk_read, snk_write}, 2'b01);
      chk("C_full_wait", src_waitrequest, 2'b01);
      chk("C_full_wdata", snk_writedata, 64'hC0FFEE);
      tick();
      src_write = '0;
      @(negedge clk);
      chk("C_blocked", {snk_read, src_waitrequest[0]}, 2'b01);
      tick();
      beat_on(64'hC1);
      @(negedge clk);
      chk("C_pop_cycle", snk_read, 1'b0);
      tick();
      snk_readdatavalid = 1'b0;
      @(negedge clk);
      chk("C_after_pop", {snk_read, snk_address}, {1'b1, src_addr(0)});
      rdq.push_back('{0, 1});
      tick();
      src_read = '0;
      beats(4, 64'hC2);

      // Write burst of 8 with a 2-cycle gap; source 1 reads meanwhile.
      acc_log.delete();
      src_burstcount[0 +: BW] = BW'(8);
      widx = 0;
      for (int t = 0; t < 11; t++) begin
         if (t < 3 || (t >= 5 && t < 10)) begin
            src_write = 2'b01;
            src_writedata[0 +: DW] = 64'hD000 + DW'(widx);
            widx++;
         end else begin
            src_write = 2'b00;
         end
         src_read = (t >= 1) ? 2'b10 : 2'b00;
         @(negedge clk);
         if (t >= 1 && t < 10) chk($sformatf("D_wait1_t%0d", t), src_waitrequest[1], 1'b1);
         if (t == 3 || t == 4) chk($sformatf("D_gap_t%0d", t), {snk_read, snk_write}, 2'b00);
         if (t == 10) begin
            chk("D_rd_after", {snk_read, snk_address}, {1'b1, src_addr(1)});
            rdq.push_back('{1, 1});
         end
         tick();
      end
      src_read  = '0;
      src_write = '0;
      chk("D_log_n", acc_log.size(), 9);
      for (int i = 0; i < 9 && i < acc_log.size(); i++) begin
         if (i < 8) chk($sformatf("D_beat%0d", i), {acc_log[i].wr, acc_log[i].d}, {1'b1, 64'hD000 + 64'(i)});
         else chk("D_final_rd", {acc_log[i].wr, acc_log[i].a}, {1'b0, src_addr(1)});
      end
      beats(1, 64'hD100);

      // Sink stalls for 5 cycles: grant holds, nothing advances until accept.
      src_burstcount[0 +: BW] = BW'(1);
      src_read = 2'b11;
      snk_waitrequest = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("E_hold%0d", k), {snk_read, snk_address, src_waitrequest}, {1'b1, src_addr(0), 2'b11});
         tick();
      end
      snk_waitrequest = 1'b0;
      @(negedge clk);
      chk("E_acc0", {snk_address, src_waitrequest}, {src_addr(0), 2'b10});
      rdq.push_back('{0, 1});
      tick();
      @(negedge clk);
      chk("E_acc1", {snk_address, src_waitrequest}, {src_addr(1), 2'b01});
      rdq.push_back('{1, 1});
      tick();
      src_read = '0;
      beats(2, 64'hE0);

      // Response with nothing outstanding.
      beat_on(64'hF0);
      tick();
      snk_readdatavalid = 1'b0;
      @(negedge clk);
      chk("F_no_rdv", 64'(src_readdatavalid), 64'(0));
      chk("F_err_set", rsp_error, 1'b1);
      repeat (3) tick();
      @(negedge clk);
      chk("F_err_sticky", rsp_error, 1'b1);
      tick();
      reset_n = 1'b0;
      #1;
      chk("F_err_async_clr", rsp_error, 1'b0);
      tick();
      reset_n = 1'b1;
      repeat (2) tick();
      chk("model_drained", exq.size() + rdq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
